// File: rtl/vram_pixel_fetcher.sv
// Video display-port reader for the shared video RAM.
// Fetches one line of bytes and streams them out MSB-first, one pixel per ce_pix.
module vram_pixel_fetcher #(
   parameter int addr_width_g     = 14,
   parameter int bytes_per_line_g = 40,
   parameter int lines_g          = 192
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    ce_pix,
   input  logic                    frame_start,
   input  logic                    line_start,
   input  logic [addr_width_g-1:0] base_addr,
   output logic                    ram_enable,
   output logic [addr_width_g-1:0] ram_address,
   input  logic [7:0]              ram_q,
   output logic                    pixel,
   output logic                    pixel_valid,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE,
      PREFETCH,
      ACTIVE,
      DRAIN
   } state_t;

   localparam logic [7:0]  LINES  = 8'(lines_g);
   localparam logic [7:0]  BPL_M1 = 8'(bytes_per_line_g - 1);
   localparam logic [15:0] BPL    = 16'(bytes_per_line_g);
   localparam logic [addr_width_g-1:0] ONE = 1;

   state_t                  state_q, state_d;
   logic [7:0]              line_cnt_q, line_cnt_d;
   logic [addr_width_g-1:0] base_q, base_d;
   logic [addr_width_g-1:0] fetch_q, fetch_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              byte_cnt_q, byte_cnt_d;
   logic [7:0]              pref_q, pref_d;
   logic [7:0]              shift_q, shift_d;
   logic                    cap_q, cap_d;
   logic                    en_q, en_d;
   logic [addr_width_g-1:0] addr_q, addr_d;
   logic                    pix_q, pix_d;
   logic                    val_q, val_d;
   logic                    busy_q, busy_d;
   logic [15:0]             line_off;
   logic [addr_width_g-1:0] line_addr;

   assign ram_enable  = en_q;
   assign ram_address = addr_q;
   assign pixel       = pix_q;
   assign pixel_valid = val_q;
   assign busy        = busy_q;

   // State register and all datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         line_cnt_q <= '0;
         base_q     <= '0;
         fetch_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         pref_q     <= '0;
         shift_q    <= '0;
         cap_q      <= 1'b0;
         en_q       <= 1'b0;
         addr_q     <= '0;
         pix_q      <= 1'b0;
         val_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         base_q     <= base_d;
         fetch_q    <= fetch_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         pref_q     <= pref_d;
         shift_q    <= shift_d;
         cap_q      <= cap_d;
         en_q       <= en_d;
         addr_q     <= addr_d;
         pix_q      <= pix_d;
         val_q      <= val_d;
         busy_q     <= busy_d;
      end
   end

   // Start address of the current line, wrapping at the RAM size.
   always_comb begin
      line_off  = {8'd0, line_cnt_q} * BPL;
      line_addr = base_q + addr_width_g'(line_off);
   end

   // Next-state, fetch sequencing and serialiser.
   always_comb begin
      state_d    = state_q;
      line_cnt_d = line_cnt_q;
      base_d     = base_q;
      fetch_d    = fetch_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      pref_d     = pref_q;
      shift_d    = shift_q;
      cap_d      = en_q;
      en_d       = 1'b0;
      addr_d     = addr_q;
      pix_d      = pix_q;
      val_d      = val_q;
      // RAM data is valid the clock after the enable cycle.
      if (cap_q) begin
         pref_d = ram_q;
      end
      if (frame_start) begin
         state_d    = IDLE;
         pix_d      = 1'b0;
         val_d      = 1'b0;
         cap_d      = 1'b0;
         line_cnt_d = '0;
         base_d     = base_addr;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (line_start && (line_cnt_q < LINES)) begin
                  en_d       = 1'b1;
                  addr_d     = line_addr;
                  fetch_d    = line_addr + ONE;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  state_d    = PREFETCH;
               end
            end
            PREFETCH: begin
               if (cap_q) begin
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (ce_pix) begin
                  if (bit_cnt_q == 3'd0) begin
                     pix_d   = pref_q[7];
                     shift_d = {pref_q[6:0], 1'b0};
                     val_d   = 1'b1;
                     if (byte_cnt_q < BPL_M1) begin
                        en_d    = 1'b1;
                        addr_d  = fetch_q;
                        fetch_d = fetch_q + ONE;
                     end
                  end else begin
                     pix_d   = shift_q[7];
                     shift_d = {shift_q[6:0], 1'b0};
                  end
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_cnt_d = byte_cnt_q + 8'd1;
                     if (byte_cnt_q == BPL_M1) begin
                        state_d = DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (ce_pix) begin
                  pix_d   = 1'b0;
                  val_d   = 1'b0;
                  state_d = IDLE;
                  if (line_cnt_q != 8'hFF) begin
                     line_cnt_d = line_cnt_q + 8'd1;
                  end
               end
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_vram_pixel_fetcher.sv
// Scoreboard bench for vram_pixel_fetcher.
// Two instances: full-size line geometry, and 1-byte lines for the frame limit.
module tb_vram_pixel_fetcher;

   logic        clock = 1'b0;
   logic        clk_run = 1'b1;
   logic        reset_n;
   logic        ce_pix;
   logic        frame_start, line_start;
   logic [13:0] base_addr;
   logic        ram_enable;
   logic [13:0] ram_address;
   logic [7:0]  ram_q;
   logic        pixel, pixel_valid, busy;

   logic        lim_fs, lim_ls;
   logic [13:0] lim_base;
   logic        lim_en;
   logic [13:0] lim_addr;
   logic [7:0]  lim_q;
   logic        lim_pix, lim_val, lim_busy;

   logic [7:0]  mem [0:16383];
   logic [13:0] aq[$];
   logic        pq[$];
   logic [13:0] laq[$];

   int tests = 0;
   int fails = 0;
   int pix_cnt = 0;
   int lim_en_cnt = 0;
   int lim_pix_cnt = 0;

   vram_pixel_fetcher #(
      .addr_width_g(14), .bytes_per_line_g(40), .lines_g(192)
   ) u_dut (
      .clock(clock), .reset_n(reset_n), .ce_pix(ce_pix),
      .frame_start(frame_start), .line_start(line_start),
      .base_addr(base_addr), .ram_enable(ram_enable),
      .ram_address(ram_address), .ram_q(ram_q), .pixel(pixel),
      .pixel_valid(pixel_valid), .busy(busy)
   );

   vram_pixel_fetcher #(
      .addr_width_g(14), .bytes_per_line_g(1), .lines_g(192)
   ) u_lim (
      .clock(clock), .reset_n(reset_n), .ce_pix(ce_pix),
      .frame_start(lim_fs), .line_start(lim_ls),
      .base_addr(lim_base), .ram_enable(lim_en),
      .ram_address(lim_addr), .ram_q(lim_q), .pixel(lim_pix),
      .pixel_valid(lim_val), .busy(lim_busy)
   );

   always #5 if (clk_run) clock = ~clock;

   always @(posedge clock) begin
      if (ram_enable) ram_q <= mem[ram_address];
      if (lim_en) lim_q <= mem[lim_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: got event, expected none queued", nm);
   endtask

   // pixel-enable generator: one pulse every 2 clocks
   initial begin
      ce_pix = 1'b0;
      forever begin
         @(negedge clock);
         ce_pix = !ce_pix;
      end
   end

   // monitor for the main instance
   initial begin
      logic ce_s;
      logic en_prev;
      en_prev = 1'b0;
      forever begin
         @(posedge clock);
         ce_s = ce_pix;
         @(negedge clock);
         if (ram_enable) begin
            chk("en_single_cycle", 32'(en_prev), 0);
            if (aq.size() == 0) miss("ram_enable");
            else chk("ram_address", 32'(ram_address), 32'(aq.pop_front()));
         end
         en_prev = ram_enable;
         if (ce_s && pixel_valid) begin
            pix_cnt++;
            if (pq.size() == 0) miss("pixel");
            else chk("pixel", 32'(pixel), 32'(pq.pop_front()));
         end
      end
   end

   // monitor for the frame-limit instance
   initial begin
      logic ce_s;
      forever begin
         @(posedge clock);
         ce_s = ce_pix;
         @(negedge clock);
         if (lim_en) begin
            lim_en_cnt++;
            if (laq.size() == 0) miss("lim_ram_enable");
            else chk("lim_address", 32'(lim_addr), 32'(laq.pop_front()));
         end
         if (ce_s && lim_val) lim_pix_cnt++;
      end
   end

   task automatic pulse_fs(input logic [13:0] b);
      @(negedge clock);
      frame_start = 1'b1;
      base_addr = b;
      @(negedge clock);
      frame_start = 1'b0;
   endtask

   task automatic push_line(input logic [13:0] start);
      logic [13:0] a;
      logic [7:0]  d;
      for (int k = 0; k < 40; k++) begin
         a = start + 14'(k);
         d = mem[a];
         aq.push_back(a);
         for (int b = 7; b >= 0; b--) pq.push_back(d[b]);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (busy) chk({nm, "_timeout"}, 1, 0);
   endtask

   task automatic run_line(input logic [13:0] start, input bit poke);
      push_line(start);
      pix_cnt = 0;
      @(negedge clock);
      line_start = 1'b1;
      @(negedge clock);
      line_start = 1'b0;
      chk("busy_rise", 32'(busy), 1);
      if (poke) begin
         repeat (100) @(negedge clock);
         line_start = 1'b1;
         @(negedge clock);
         line_start = 1'b0;
      end
      wait_idle("line");
      chk("pix_count", pix_cnt, 320);
      chk("valid_low_end", 32'(pixel_valid), 0);
   endtask

   task automatic lim_line(input logic [13:0] a, input bit take);
      int n;
      if (take) laq.push_back(a);
      @(negedge clock);
      lim_ls = 1'b1;
      @(negedge clock);
      lim_ls = 1'b0;
      n = 0;
      while (lim_busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (lim_busy) chk("lim_timeout", 1, 0);
   endtask

   initial begin
      int e0, p0;
      for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
      mem[14'h0100] = 8'hA5;
      reset_n = 1'b0;
      frame_start = 1'b0;
      line_start = 1'b0;
      base_addr = '0;
      lim_fs = 1'b0;
      lim_ls = 1'b0;
      lim_base = '0;
      repeat (3) @(negedge clock);
      chk("rst_enable", 32'(ram_enable), 0);
      chk("rst_address", 32'(ram_address), 0);
      chk("rst_pixel", 32'(pixel), 0);
      chk("rst_valid", 32'(pixel_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      reset_n = 1'b1;

      // first line (starts with 0xA5), then line 1 at base+40
      pulse_fs(14'h0100);
      run_line(14'h0100, 1'b1);
      run_line(14'h0128, 1'b0);

      // address wrap at the top of RAM
      pulse_fs(14'h3FF0);
      run_line(14'h3FF0, 1'b0);

      // frame_start together with line_start mid-line
      pulse_fs(14'h0100);
      push_line(14'h0100);
      @(negedge clock);
      line_start = 1'b1;
      @(negedge clock);
      line_start = 1'b0;
      repeat (60) @(negedge clock);
      frame_start = 1'b1;
      line_start = 1'b1;
      base_addr = 14'h0200;
      @(negedge clock);
      frame_start = 1'b0;
      line_start = 1'b0;
      chk("abort_valid", 32'(pixel_valid), 0);
      chk("abort_pixel", 32'(pixel), 0);
      chk("abort_enable", 32'(ram_enable), 0);
      chk("abort_busy", 32'(busy), 0);
      aq.delete();
      pq.delete();
      run_line(14'h0200, 1'b0);

      // 192-line frame limit on the 1-byte-per-line instance
      @(negedge clock);
      lim_fs = 1'b1;
      lim_base = 14'h0000;
      @(negedge clock);
      lim_fs = 1'b0;
      for (int k = 0; k < 192; k++) lim_line(14'(k), 1'b1);
      chk("lim_en_192", lim_en_cnt, 192);
      chk("lim_pix_192", lim_pix_cnt, 1536);
      e0 = lim_en_cnt;
      p0 = lim_pix_cnt;
      lim_line(14'h0000, 1'b0);
      repeat (20) @(negedge clock);
      chk("lim_193_no_en", lim_en_cnt, e0);
      chk("lim_193_no_pix", lim_pix_cnt, p0);
      @(negedge clock);
      lim_fs = 1'b1;
      lim_base = 14'h0055;
      @(negedge clock);
      lim_fs = 1'b0;
      lim_line(14'h0055, 1'b1);
      chk("lim_resume_en", lim_en_cnt, 193);

      // async reset mid-line with the clock stopped
      pulse_fs(14'h0300);
      push_line(14'h0300);
      @(negedge clock);
      line_start = 1'b1;
      @(negedge clock);
      line_start = 1'b0;
      repeat (50) @(negedge clock);
      clk_run = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_enable", 32'(ram_enable), 0);
      chk("arst_address", 32'(ram_address), 0);
      chk("arst_pixel", 32'(pixel), 0);
      chk("arst_valid", 32'(pixel_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      aq.delete();
      pq.delete();
      #2;
      reset_n = 1'b1;
      #2;
      clk_run = 1'b1;
      run_line(14'h0000, 1'b0);

      repeat (4) @(negedge clock);
      chk("addr_queue_empty", aq.size(), 0);
      chk("pix_queue_empty", pq.size(), 0);
      chk("lim_queue_empty", laq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
